// File: rtl/score_round_ctrl.sv
// Round sequencer for the bomb-defuse game: times each round, accumulates a BCD score,
// tracks the defuse streak and hands score/multiplier to the multiply stage via req/done.
module score_round_ctrl #(
    parameter int ROUNDS         = 4,
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int ROUND_SECS     = 9,
    parameter int PTS_PER_DEFUSE = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Defused,
    input  logic       Exploded,
    input  logic       MulDone,
    output logic [7:0] PlayerScore,
    output logic [1:0] Multiplier,
    output logic       MulReq,
    output logic [2:0] Round,
    output logic [3:0] SecsLeft,
    output logic [2:0] State,
    output logic       GameOver
);

    localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    SECS_INIT = 4'(ROUND_SECS);
    localparam logic [3:0]    PTS       = 4'(PTS_PER_DEFUSE);
    localparam logic [2:0]    LAST_RND  = 3'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_SCORE    = 3'd3,
        S_NEXT     = 3'd4,
        S_MUL_REQ  = 3'd5,
        S_MUL_WAIT = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t        r_state;
    logic [7:0]    r_score;
    logic [1:0]    r_mult;
    logic          r_mul_req;
    logic [2:0]    r_round;
    logic [3:0]    r_secs;
    logic          r_game_over;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_streak;
    logic          r_start_q;

    logic          w_start_edge;
    logic          w_wrap;
    logic [4:0]    w_ones_sum;
    logic          w_carry;
    logic [3:0]    w_ones_next;
    logic [4:0]    w_tens_next;
    logic [7:0]    w_score_sum;

    assign w_start_edge = Start & ~r_start_q;
    assign w_wrap       = (r_tick == TICK_MAX);

    // BCD add of one digit constant; 4-bit wrap of (ones+PTS-10) is exact when carrying.
    assign w_ones_sum  = {1'b0, r_score[3:0]} + {1'b0, PTS};
    assign w_carry     = (w_ones_sum > 5'd9);
    assign w_ones_next = w_carry ? (r_score[3:0] + PTS - 4'd10) : w_ones_sum[3:0];
    assign w_tens_next = {1'b0, r_score[7:4]} + {4'b0000, w_carry};
    assign w_score_sum = (w_tens_next > 5'd9) ? 8'h99 : {w_tens_next[3:0], w_ones_next};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_score     <= 8'h00;
            r_mult      <= 2'b01;
            r_mul_req   <= 1'b0;
            r_round     <= 3'd0;
            r_secs      <= 4'd0;
            r_game_over <= 1'b0;
            r_tick      <= '0;
            r_streak    <= 2'd0;
            r_start_q   <= 1'b1;
        end else begin
            r_start_q <= Start;
            r_mul_req <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_score     <= 8'h00;
                        r_streak    <= 2'd0;
                        r_mult      <= 2'b01;
                        r_round     <= 3'd1;
                        r_secs      <= SECS_INIT;
                        r_tick      <= '0;
                        r_game_over <= 1'b0;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_secs  <= SECS_INIT;
                    r_tick  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_tick <= '0;
                        if (r_secs != 4'd0) r_secs <= r_secs - 4'd1;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                    // Explosion beats a simultaneous defuse; a defuse beats a simultaneous timeout.
                    if (Exploded) begin
                        r_streak <= 2'd0;
                        r_state  <= S_NEXT;
                    end else if (Defused) begin
                        r_state <= S_SCORE;
                    end else if (w_wrap && r_secs == 4'd1) begin
                        r_streak <= 2'd0;
                        r_state  <= S_NEXT;
                    end
                end
                S_SCORE: begin
                    r_score  <= w_score_sum;
                    r_streak <= (r_streak == 2'd3) ? 2'd3 : r_streak + 2'd1;
                    r_state  <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_round == LAST_RND) begin
                        r_mult    <= (r_streak == 2'd0) ? 2'b01 : r_streak;
                        r_mul_req <= 1'b1;
                        r_state   <= S_MUL_REQ;
                    end else begin
                        r_round <= r_round + 3'd1;
                        r_secs  <= SECS_INIT;
                        r_tick  <= '0;
                        r_state <= S_ARM;
                    end
                end
                S_MUL_REQ: begin
                    r_state <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    if (MulDone) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PlayerScore = r_score;
    assign Multiplier  = r_mult;
    assign MulReq      = r_mul_req;
    assign Round       = r_round;
    assign SecsLeft    = r_secs;
    assign State       = r_state;
    assign GameOver    = r_game_over;

endmodule

// File: tb/tb_score_round_ctrl.sv
// Directed bench for score_round_ctrl: main instance with 4 rounds x 5 points and a
// second instance with 7 rounds x 9 points for BCD carry and saturation.
module tb_score_round_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_RUN = 3'd2, ST_SCORE = 3'd3,
                           ST_NEXT = 3'd4, ST_MREQ = 3'd5, ST_MWAIT = 3'd6, ST_DONE = 3'd7;

    logic Clk;
    logic Rst, Start, Defused, Exploded, MulDone;
    logic [7:0] PlayerScore;
    logic [1:0] Multiplier;
    logic       MulReq, GameOver;
    logic [2:0] Round, State;
    logic [3:0] SecsLeft;

    logic s_rst, s_start, s_def, s_done;
    logic [7:0] s_score;
    logic [1:0] s_mult;
    logic       s_mul_req, s_game_over;
    logic [2:0] s_round, s_state;
    logic [3:0] s_secs;

    int n_tests = 0;
    int n_fail  = 0;

    score_round_ctrl #(.ROUNDS(4), .TICKS_PER_SEC(4), .ROUND_SECS(3), .PTS_PER_DEFUSE(5)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Defused(Defused), .Exploded(Exploded),
        .MulDone(MulDone), .PlayerScore(PlayerScore), .Multiplier(Multiplier), .MulReq(MulReq),
        .Round(Round), .SecsLeft(SecsLeft), .State(State), .GameOver(GameOver)
    );

    score_round_ctrl #(.ROUNDS(7), .TICKS_PER_SEC(4), .ROUND_SECS(3), .PTS_PER_DEFUSE(9)) dut_s (
        .Clk(Clk), .Rst(s_rst), .Start(s_start), .Defused(s_def), .Exploded(1'b0),
        .MulDone(s_done), .PlayerScore(s_score), .Multiplier(s_mult), .MulReq(s_mul_req),
        .Round(s_round), .SecsLeft(s_secs), .State(s_state), .GameOver(s_game_over)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, 32'(State), 32'(ST_IDLE));
        check_eq({tag, "_score"}, 32'(PlayerScore), 32'h00);
        check_eq({tag, "_mult"}, 32'(Multiplier), 32'd1);
        check_eq({tag, "_mulreq"}, 32'(MulReq), 32'd0);
        check_eq({tag, "_round"}, 32'(Round), 32'd0);
        check_eq({tag, "_secs"}, 32'(SecsLeft), 32'd0);
        check_eq({tag, "_gameover"}, 32'(GameOver), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (State != st && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check_eq("wait_state", 32'(State), 32'(st));
    endtask

    // Driver tasks. kind: 0 defuse, 1 explode, 2 defuse+explode, 3 timeout
    task automatic do_round(input int kind, input logic [2:0] rnd, input logic [7:0] exp_score);
        int n;
        wait_state(ST_RUN, 50);
        check_eq("round_num", 32'(Round), 32'(rnd));
        case (kind)
            0: begin
                Defused = 1'b1;
                @(negedge Clk);
                Defused = 1'b0;
                check_eq("defuse_to_score", 32'(State), 32'(ST_SCORE));
                @(negedge Clk);
                check_eq("score_to_next", 32'(State), 32'(ST_NEXT));
            end
            1, 2: begin
                Exploded = 1'b1;
                Defused  = (kind == 2);
                @(negedge Clk);
                Exploded = 1'b0;
                Defused  = 1'b0;
                check_eq("explode_to_next", 32'(State), 32'(ST_NEXT));
            end
            default: begin
                n = 0;
                while (State != ST_NEXT && n < 40) begin
                    @(negedge Clk);
                    n++;
                end
                check_eq("timeout_cycles", 32'(n), 32'd12);
                check_eq("timeout_secs", 32'(SecsLeft), 32'd0);
            end
        endcase
        check_eq("round_score", 32'(PlayerScore), 32'(exp_score));
    endtask

    task automatic start_game();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("start_arm", 32'(State), 32'(ST_ARM));
        check_eq("start_round", 32'(Round), 32'd1);
        check_eq("start_secs", 32'(SecsLeft), 32'd3);
        check_eq("start_score", 32'(PlayerScore), 32'h00);
        check_eq("start_gameover", 32'(GameOver), 32'd0);
    endtask

    task automatic finish_game(input logic [1:0] exp_mult, input logic [7:0] exp_score,
                               input logic done_in_req);
        @(negedge Clk);
        check_eq("mul_req_state", 32'(State), 32'(ST_MREQ));
        check_eq("mul_req_high", 32'(MulReq), 32'd1);
        check_eq("mult_value", 32'(Multiplier), 32'(exp_mult));
        MulDone = done_in_req;
        @(negedge Clk);
        MulDone = 1'b0;
        check_eq("mul_wait_state", 32'(State), 32'(ST_MWAIT));
        check_eq("mul_req_single", 32'(MulReq), 32'd0);
        repeat (4) @(negedge Clk);
        check_eq("mul_wait_hold", 32'(State), 32'(ST_MWAIT));
        MulDone = 1'b1;
        @(negedge Clk);
        MulDone = 1'b0;
        check_eq("done_state", 32'(State), 32'(ST_DONE));
        check_eq("done_gameover", 32'(GameOver), 32'd1);
        check_eq("done_score", 32'(PlayerScore), 32'(exp_score));
        check_eq("done_mult", 32'(Multiplier), 32'(exp_mult));
        check_eq("done_round", 32'(Round), 32'd4);
    endtask

    task automatic s_round_defuse(input logic [7:0] exp_score);
        int n = 0;
        while (s_state != ST_RUN && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check_eq("sat_wait_run", 32'(s_state), 32'(ST_RUN));
        s_def = 1'b1;
        @(negedge Clk);
        s_def = 1'b0;
        @(negedge Clk);
        check_eq("sat_score", 32'(s_score), 32'(exp_score));
        check_eq("sat_ones_digit", 32'(s_score[3:0] <= 4'd9), 32'd1);
    endtask

    // Stimulus and scoreboard
    initial begin
        logic [7:0] sat_exp [7];
        sat_exp = '{8'h09, 8'h18, 8'h27, 8'h36, 8'h45, 8'h54, 8'h63};
        Rst = 1'b1; Start = 1'b1; Defused = 1'b0; Exploded = 1'b0; MulDone = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_def = 1'b0; s_done = 1'b0;

        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("start_held_idle", 32'(State), 32'(ST_IDLE));
        Start = 1'b0;
        @(negedge Clk);
        start_game();

        // All four rounds defused early
        do_round(0, 3'd1, 8'h05);
        do_round(0, 3'd2, 8'h10);
        do_round(0, 3'd3, 8'h15);
        do_round(0, 3'd4, 8'h20);
        finish_game(2'b11, 8'h20, 1'b0);

        // Round 2 times out; MulDone during MUL_REQ is ignored
        start_game();
        do_round(0, 3'd1, 8'h05);
        do_round(3, 3'd2, 8'h05);
        do_round(0, 3'd3, 8'h10);
        do_round(0, 3'd4, 8'h15);
        finish_game(2'b10, 8'h15, 1'b1);

        // Defuse during ARM is ignored; defuse+explode clears the streak
        start_game();
        Defused = 1'b1;
        @(negedge Clk);
        Defused = 1'b0;
        check_eq("arm_defuse_ignored", 32'(State), 32'(ST_RUN));
        do_round(0, 3'd1, 8'h05);
        do_round(2, 3'd2, 8'h05);
        do_round(0, 3'd3, 8'h10);
        do_round(0, 3'd4, 8'h15);
        finish_game(2'b10, 8'h15, 1'b0);

        // Every round explodes
        start_game();
        do_round(1, 3'd1, 8'h00);
        do_round(1, 3'd2, 8'h00);
        do_round(1, 3'd3, 8'h00);
        do_round(1, 3'd4, 8'h00);
        finish_game(2'b01, 8'h00, 1'b0);

        // Reset mid-RUN
        start_game();
        wait_state(ST_RUN, 10);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_outputs("rst_run");
        @(negedge Clk);
        start_game();
        do_round(0, 3'd1, 8'h05);
        do_round(1, 3'd2, 8'h05);
        do_round(1, 3'd3, 8'h05);
        do_round(1, 3'd4, 8'h05);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("pre_rst_wait", 32'(State), 32'(ST_MWAIT));
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_outputs("rst_wait");
        MulDone = 1'b1;
        @(negedge Clk);
        MulDone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("late_done_idle", 32'(State), 32'(ST_IDLE));
            check_eq("late_done_noreq", 32'(MulReq), 32'd0);
            @(negedge Clk);
        end

        // Saturation instance
        s_rst = 1'b0;
        @(negedge Clk);
        s_start = 1'b1;
        @(negedge Clk);
        s_start = 1'b0;
        check_eq("sat_arm", 32'(s_state), 32'(ST_ARM));
        for (int i = 0; i < 7; i++) s_round_defuse(sat_exp[i]);
        @(negedge Clk);
        check_eq("sat_mreq", 32'(s_mul_req), 32'd1);
        check_eq("sat_mult", 32'(s_mult), 32'd3);
        @(negedge Clk);
        s_done = 1'b1;
        @(negedge Clk);
        s_done = 1'b0;
        check_eq("sat_done", 32'(s_state), 32'(ST_DONE));
        s_start = 1'b1;
        @(negedge Clk);
        s_start = 1'b0;
        @(negedge Clk);
        check_eq("sat_run2", 32'(s_state), 32'(ST_RUN));
        force dut_s.r_score = 8'h95;
        @(negedge Clk);
        release dut_s.r_score;
        check_eq("sat_preload", 32'(s_score), 32'h95);
        s_round_defuse(8'h99);
        s_round_defuse(8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_round_ctrl.md
Name: score_round_ctrl

Overview:
- Game-level sequencer for the bomb-defuse round loop.
- Runs ROUNDS timed rounds and accumulates a two-digit BCD PlayerScore from defuse events.
- Tracks the consecutive-defuse streak, derives Multiplier from it, then hands PlayerScore/Multiplier to the score-multiply/display stage via a req/done handshake.
- Sits between the button/bomb-event logic and the score-multiply stage.

Parameters:
- ROUNDS, 4, rounds per game (1..7).
- TICKS_PER_SEC, 50000000, Clk cycles per countdown second (>=2).
- ROUND_SECS, 9, countdown start value per round, BCD digit (1..9).
- PTS_PER_DEFUSE, 5, points per defuse, BCD digit (1..9).

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  level; rising edge launches a game.
- Defused  in  1  one-cycle pulse, bomb defused.
- Exploded  in  1  one-cycle pulse, bomb exploded.
- MulDone  in  1  multiply stage finished; level or pulse.
- PlayerScore  out  8  BCD score: [7:4] tens, [3:0] ones.
- Multiplier  out  2  2'b01/2'b10/2'b11.
- MulReq  out  1  one-cycle request to multiply stage.
- Round  out  3  current round, 1-based.
- SecsLeft  out  4  countdown seconds remaining.
- State  out  3  FSM state encoding.
- GameOver  out  1  high in DONE.

Behaviour:
- Reset (sync, active-high):
  - Outputs: State=IDLE, PlayerScore=0, Multiplier=2'b01, MulReq=0, Round=0, SecsLeft=0, GameOver=0.
  - Internals: tick counter=0, streak=0, start_q=1. With start_q=1, a Start held through reset does not launch a game.
  - Reset asserted in any state, including mid-round or mid-handshake, takes effect at the next edge and overrides all other inputs.
- Start edge: start_q registers Start each cycle. The edge is Start & ~start_q.
- State encoding: IDLE=0, ARM=1, RUN=2, SCORE=3, NEXT=4, MUL_REQ=5, MUL_WAIT=6, DONE=7.
- IDLE: on Start edge -> ARM; PlayerScore=0, streak=0, Round=1.
- ARM (1 cycle): SecsLeft=ROUND_SECS, tick=0 -> RUN.
- RUN: tick increments each cycle. When tick==TICKS_PER_SEC-1, tick wraps to 0 and SecsLeft decrements.
  - Defused=1 -> SCORE.
  - Exploded=1 -> NEXT; streak=0; no points.
  - Timeout (SecsLeft==1 and tick wrap) -> SecsLeft=0, NEXT; streak=0; no points.
  - Defused and Exploded in the same cycle: Exploded wins.
  - Defused in the same cycle as timeout: Defused wins, SecsLeft still decrements to 0.
  - Defused/Exploded are ignored in all states other than RUN.
- SCORE (1 cycle): PlayerScore += PTS_PER_DEFUSE in BCD; streak = min(streak+1, 3); -> NEXT.
  - Ones digit: s = ones + PTS. If s>9, ones = s-10 and tens += 1.
  - If tens would exceed 9, PlayerScore saturates to 8'h99.
  - Digits never hold values >9.
- NEXT (1 cycle): if Round==ROUNDS -> MUL_REQ; else Round += 1 -> ARM.
- MUL_REQ (1 cycle):
  - Multiplier = 2'b01 if streak==0, else streak[1:0].
  - MulReq=1 for exactly this cycle; -> MUL_WAIT.
- MUL_WAIT: hold all outputs; MulReq=0. On MulDone=1 -> DONE.
  - MulDone seen in any other state is ignored.
  - MulDone asserted in the MUL_REQ cycle is ignored; only MUL_WAIT samples it.
- DONE: GameOver=1. PlayerScore, Multiplier and Round stay frozen.
  - On Start edge -> IDLE-equivalent init (score 0, streak 0, Round 1), then ARM. GameOver drops in the cycle ARM is entered.
- Start edges outside IDLE/DONE are ignored.
- PlayerScore and Multiplier are stable from the MUL_REQ cycle until the next game start.
- Timing: Defused pulse to PlayerScore update is 2 edges (RUN->SCORE, then SCORE registers the sum).

Test Plan:
(sim parameters: TICKS_PER_SEC=4, ROUND_SECS=3, ROUNDS=4, PTS_PER_DEFUSE=5)
- Start held high through reset release, no new edge -> stays IDLE. Then toggle Start 0->1 -> ARM next edge, Round=1, SecsLeft=3.
- Defuse all 4 rounds early:
  - PlayerScore steps 8'h05, 8'h10, 8'h15, 8'h20.
  - Streak saturates at 3, so Multiplier=2'b11.
  - Single-cycle MulReq. With MulDone 5 cycles later -> DONE, GameOver=1, PlayerScore=8'h20.
- Round 1 defuse, round 2 timeout, rounds 3-4 defuse:
  - Round 2 timeout fires exactly 12 cycles after entering RUN.
  - Final PlayerScore=8'h15, Multiplier=2'b10.
- Defused and Exploded pulsed in the same RUN cycle -> no score change, streak reset. All rounds exploding -> PlayerScore=8'h00, Multiplier=2'b01.
- Saturation: PTS_PER_DEFUSE=9, ROUNDS=7, defuse all rounds.
  - Score sequence 09,18,27,36,45,54,63.
  - Preload check via ROUNDS=7 with PTS=9 and forced initial score 8'h95 -> 8'h99.
  - Ones digit never exceeds 9.
- Rst pulsed mid-RUN and again during MUL_WAIT -> all outputs return to reset values next edge. MulReq never re-asserts without a new game; late MulDone is ignored.
